// File: rtl/scope_trig_capture.sv
// -----------------------------------------------------------------------------
// scope_trig_capture
//
// Trigger-and-capture stage of the scope path. It takes the registered,
// sign-corrected 12-bit samples from the ADC front-end. Once armed, it keeps a
// circular pre-trigger history in on-chip RAM and waits for a level-crossing
// trigger or a forced trigger. It then completes one frame of DEPTH samples and
// replays that frame, oldest sample first, over a valid/ready stream.
//
// Ports
//   i_clk           sample/system clock (same clock as the ADC front-end)
//   i_rst           synchronous, active-high reset
//   i_sample        signed 12-bit sample from the front-end
//   i_sample_en     sample qualifier (full rate or decimated)
//   i_arm           single-cycle pulse that starts a capture (IDLE only)
//   i_force         forces the trigger while waiting for it
//   i_trig_level    signed trigger threshold
//   i_trig_falling  edge select: 0 = rising, 1 = falling
//   i_pre_len       number of pre-trigger samples, latched on arm
//   o_busy          high in every state except IDLE
//   o_done          one-cycle pulse after the last readout beat is accepted
//   o_rd_data       readout sample
//   o_rd_valid      readout beat valid
//   i_rd_ready      downstream accept
//   o_rd_last       marks the final (DEPTH-th) beat of the frame
// -----------------------------------------------------------------------------
module scope_trig_capture #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic signed [11:0] i_sample,
  input  logic               i_sample_en,
  input  logic               i_arm,
  input  logic               i_force,
  input  logic signed [11:0] i_trig_level,
  input  logic               i_trig_falling,
  input  logic [AW-1:0]      i_pre_len,
  output logic               o_busy,
  output logic               o_done,
  output logic signed [11:0] o_rd_data,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic               o_rd_last
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_READ = 3'd4
  } state_t;

  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LAST_IDX  = (AW + 1)'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_AW    = AW'(1'b1);

  // Signed level-crossing test on two consecutive qualified samples.
  function automatic logic trig_cross(
    input logic signed [11:0] prev,
    input logic signed [11:0] cur,
    input logic signed [11:0] level,
    input logic               falling
  );
    logic hit;
    if (falling) begin
      hit = (prev > level) && (cur <= level);
    end else begin
      hit = (prev < level) && (cur >= level);
    end
    return hit;
  endfunction

  // FSM state
  state_t state_r;
  state_t state_next_s;

  // Settings latched on arm
  logic [AW-1:0]      pre_len_r;
  logic signed [11:0] level_r;
  logic               falling_r;

  // Capture bookkeeping
  logic [AW-1:0]      wp_r;
  logic [AW-1:0]      cnt_r;
  logic [AW-1:0]      post_cnt_r;
  logic signed [11:0] prev_r;
  logic               have_prev_r;
  logic               force_pend_r;

  // Readout pipeline: RAM output stage followed by the output register
  logic [AW-1:0]      rd_addr_r;
  logic [AW:0]        iss_cnt_r;
  logic signed [11:0] ram_q_r;
  logic               ram_v_r;
  logic               ram_last_r;

  // Registered outputs
  logic signed [11:0] rd_data_r;
  logic               rd_valid_r;
  logic               rd_last_r;
  logic               busy_r;
  logic               done_r;

  // Frame storage
  logic signed [11:0] mem [DEPTH];

  // Decoded control strobes
  logic arm_ok_s;
  logic capturing_s;
  logic wr_en_s;
  logic level_hit_s;
  logic trig_s;
  logic xfer_s;
  logic last_xfer_s;
  logic out_free_s;
  logic ram_move_s;
  logic issue_s;

  // Control strobes derived from the current state and inputs
  always_comb begin
    arm_ok_s    = 1'b0;
    capturing_s = 1'b0;
    wr_en_s     = 1'b0;
    level_hit_s = 1'b0;
    trig_s      = 1'b0;
    xfer_s      = 1'b0;
    last_xfer_s = 1'b0;
    out_free_s  = 1'b0;
    ram_move_s  = 1'b0;
    issue_s     = 1'b0;

    // An arm coinciding with the done pulse is dropped so a new capture
    // never overlaps the tail of the previous handshake.
    arm_ok_s    = (state_r == ST_IDLE) && i_arm && !done_r;
    capturing_s = (state_r == ST_PRE) || (state_r == ST_WAIT) || (state_r == ST_POST);
    wr_en_s     = capturing_s && i_sample_en;
    level_hit_s = have_prev_r && trig_cross(prev_r, i_sample, level_r, falling_r);
    // A force on an unqualified cycle is held in force_pend_r and fires on
    // the next qualified sample.
    trig_s      = (state_r == ST_WAIT) && i_sample_en &&
                  (level_hit_s || i_force || force_pend_r);

    xfer_s      = rd_valid_r && i_rd_ready;
    last_xfer_s = xfer_s && rd_last_r;
    out_free_s  = !rd_valid_r || i_rd_ready;
    ram_move_s  = ram_v_r && out_free_s;
    issue_s     = (state_r == ST_READ) && (iss_cnt_r != DEPTH_CNT) &&
                  (!ram_v_r || out_free_s);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arm_ok_s) begin
          if (i_pre_len == '0) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_PRE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (wr_en_s && ((cnt_r + ONE_AW) == pre_len_r)) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_PRE;
        end
      end
      ST_WAIT: begin
        // post_cnt = DEPTH-1-pre_len is zero exactly when pre_len is all ones
        if (trig_s) begin
          if (&pre_len_r) begin
            state_next_s = ST_READ;
          end else begin
            state_next_s = ST_POST;
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_POST: begin
        if (wr_en_s && ((cnt_r + ONE_AW) == post_cnt_r)) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_POST;
        end
      end
      ST_READ: begin
        if (last_xfer_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_READ;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latched settings, write pointer, counters and trigger history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_len_r    <= '0;
      level_r      <= 12'sd0;
      falling_r    <= 1'b0;
      wp_r         <= '0;
      cnt_r        <= '0;
      post_cnt_r   <= '0;
      prev_r       <= 12'sd0;
      have_prev_r  <= 1'b0;
      force_pend_r <= 1'b0;
    end else if (arm_ok_s) begin
      pre_len_r    <= i_pre_len;
      level_r      <= i_trig_level;
      falling_r    <= i_trig_falling;
      wp_r         <= '0;
      cnt_r        <= '0;
      have_prev_r  <= 1'b0;
      force_pend_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wp_r        <= wp_r + ONE_AW;
        prev_r      <= i_sample;
        have_prev_r <= 1'b1;
      end
      if (trig_s) begin
        cnt_r        <= '0;
        post_cnt_r   <= ~pre_len_r;
        force_pend_r <= 1'b0;
      end else if (wr_en_s) begin
        cnt_r <= cnt_r + ONE_AW;
      end else if ((state_r == ST_WAIT) && i_force) begin
        force_pend_r <= 1'b1;
      end
    end
  end

  // Read address generation and RAM output-stage bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_addr_r  <= '0;
      iss_cnt_r  <= '0;
      ram_v_r    <= 1'b0;
      ram_last_r <= 1'b0;
    end else begin
      if (trig_s) begin
        // wp_r is the trigger sample's address on the trigger cycle
        rd_addr_r <= wp_r - pre_len_r;
        iss_cnt_r <= '0;
      end else if (issue_s) begin
        rd_addr_r <= rd_addr_r + ONE_AW;
        iss_cnt_r <= iss_cnt_r + (AW + 1)'(1'b1);
      end
      if (issue_s) begin
        ram_v_r    <= 1'b1;
        ram_last_r <= (iss_cnt_r == LAST_IDX);
      end else if (ram_move_s) begin
        ram_v_r    <= 1'b0;
        ram_last_r <= 1'b0;
      end
    end
  end

  // Frame RAM write port
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem[wp_r] <= i_sample;
    end
  end

  // Frame RAM read port; holding the output while stalled keeps the RAM stage
  // as the second half of the skid buffer
  always_ff @(posedge i_clk) begin
    if (issue_s) begin
      ram_q_r <= mem[rd_addr_r];
    end
  end

  // Output register, busy and done flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_r  <= 12'sd0;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (ram_move_s) begin
        rd_data_r  <= ram_q_r;
        rd_valid_r <= 1'b1;
        rd_last_r  <= ram_last_r;
      end else if (xfer_s) begin
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
      end
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= last_xfer_s;
    end
  end

  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_rd_data  = rd_data_r;
  assign o_rd_valid = rd_valid_r;
  assign o_rd_last  = rd_last_r;

endmodule

// File: doc/scope_trig_capture.md
# scope_trig_capture

Trigger-and-capture stage of the scope path. It sits directly downstream of the AD9226 front-end and consumes its registered, sign-corrected 12-bit samples. When armed, it keeps a circular pre-trigger history and detects a level-crossing trigger (or a forced one), then fills one frame of DEPTH samples into on-chip RAM. It then replays the frame, oldest sample first, over a valid/ready stream to the Ethernet packetiser.

## Interface
Parameters:
- DEPTH, 1024: frame length in samples; power of two, minimum 8.
- AW, 10: address width; must equal log2(DEPTH).

Ports:
- i_clk  in  1  sample/system clock, the same clock that drives the ADC front-end.
- i_rst  in  1  synchronous, active-high reset.
- i_sample  in  12 signed  sample from the front-end.
- i_sample_en  in  1  sample qualifier; tie high for full rate, or drive from a decimator.
- i_arm  in  1  single-cycle pulse that starts a capture; honoured only in IDLE.
- i_force  in  1  forces the trigger while in WAIT_TRIG.
- i_trig_level  in  12 signed  trigger threshold.
- i_trig_falling  in  1  edge select: 0 = rising, 1 = falling.
- i_pre_len  in  AW  number of pre-trigger samples (0..DEPTH-1); latched on arm.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last readout beat is accepted.
- o_rd_data  out  12 signed  readout sample.
- o_rd_valid  out  1  readout beat valid.
- i_rd_ready  in  1  downstream accept.
- o_rd_last  out  1  marks the final (DEPTH-th) beat of the frame.

## Operation
States: IDLE -> PRE -> WAIT_TRIG -> POST -> READ -> IDLE.

- **IDLE:** On i_arm, latch i_pre_len and both trigger settings (level and edge), clear the write pointer wp to 0 and the sample count, and go to PRE. If the latched pre_len is 0, go straight to WAIT_TRIG.
- **Writing:** In PRE, WAIT_TRIG and POST, every i_sample_en cycle writes i_sample to RAM[wp] and then advances wp (mod DEPTH). Cycles without i_sample_en write nothing.
- **PRE:** After pre_len writes, go to WAIT_TRIG. Triggers are ignored in this state.
- **WAIT_TRIG:** Keep writing circularly.
  - Trigger condition, evaluated only on a qualified sample that has a qualified previous sample since arm:
    - rising edge: prev < level and cur >= level;
    - falling edge: prev > level and cur <= level.
  - Comparisons are signed, 12-bit.
  - i_force triggers on any cycle of this state. If no sample is being written that cycle, the next qualified sample becomes the trigger sample.
  - On trigger, the trigger sample is written at address T. Record start = T - pre_len (mod DEPTH, AW-bit wrap), set post_cnt = DEPTH-1-pre_len, and go to POST. If post_cnt is 0, go directly to READ.
- **POST:** Perform post_cnt further writes, then go to READ. The frame is exactly pre_len samples, then the trigger sample, then DEPTH-1-pre_len samples.
- **READ:** Write-enable is off and i_sample is ignored.
  - Read addresses run start, start+1, … with wrap, for DEPTH beats.
  - The RAM read is synchronous with 1-cycle latency. A prefetch/skid register is used so that o_rd_data and o_rd_last stay stable while o_rd_valid=1 and i_rd_ready=0.
  - A beat transfers when valid and ready are both high.
  - After the DEPTH-th transfer: o_rd_valid falls, o_done pulses, and the state returns to IDLE.
- **Ignored inputs:** i_arm is ignored while busy. i_force is ignored outside WAIT_TRIG.
- **Reset:** Reset at any point, including mid-readout, returns the block to IDLE. The frame is discarded; RAM contents need not be cleared.
- **Storage:** RAM is DEPTH x 12, simple dual-port (one write port, one read port), and infers block RAM.

## Timing
- **Reset values:** o_busy=0, o_done=0, o_rd_valid=0, o_rd_last=0, o_rd_data=0.
- **Busy:** o_busy rises on the cycle after i_arm is sampled.
- **Trigger latency:** State becomes POST, or READ when post_cnt=0, on the cycle after the trigger sample is written.
- **First beat:** o_rd_valid first asserts no later than 2 cycles after entering READ.
- **Throughput:** With i_rd_ready held high, one beat transfers every cycle with no bubbles.
- **Done timing:** o_done pulses in the cycle after the last transfer. o_busy falls in that same cycle.
- **Back-to-back capture:** An arm pulse in the same cycle as o_done is ignored. The earliest new arm is honoured one cycle later.

## Test plan
Bench uses DEPTH=16, AW=4.

1. **Rising-edge ramp:** pre_len=4, level=100, rising edge; i_sample = 0,10,20,… with i_sample_en=1 -> trigger on sample 100; 16 beats read out: 60,70,80,90,100,110,…,210; o_rd_last on 210; one o_done pulse.
2. **Falling edge with decimation:** pre_len=0, falling edge, level=-5; input steps from +50 to -50; i_sample_en high every third cycle -> first beat is -50 (the trigger sample); frame holds only qualified samples.
3. **Forced trigger with wrap:** i_force asserted in WAIT_TRIG after 40 writes of a constant 7 with a counter in the low bits; pre_len=15 -> start address wraps correctly; the frame ends on the forced trigger sample; POST is skipped.
4. **Backpressure:** i_rd_ready toggles 1,0,0,1 pseudo-randomly -> o_rd_data and o_rd_last stay stable while stalled; no beats are duplicated or dropped; exactly 16 transfers.
5. **Reset and re-arm:** i_rst pulsed on readout beat 5 -> next cycle all outputs are at reset values and state is IDLE; a fresh arm captures a correct new frame. i_arm pulses while busy have no effect.
6. **No early trigger:** level=0, first sample after arm already 500, then a constant 500 -> no trigger without an actual crossing; o_busy stays 1 until i_force is applied.
